// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the ID-stage pipeline hazard controller.
package pipeline_hazard_ctrl_pkg;

  localparam int unsigned CNT_W_DEF = 32;
  localparam int unsigned WAIT_W    = 16;
  localparam int unsigned REG_W     = 5;

  localparam logic [REG_W-1:0] REG_X0 = 5'd0;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_HALT     = 2'd3
  } state_e;

  // Source operand depends on the destination of the load sitting in ID/EX.
  function automatic logic src_hits(input logic             use_src,
                                    input logic [REG_W-1:0] src,
                                    input logic [REG_W-1:0] rd);
    return use_src && (src == rd);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] q_o
);

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      q_o <= '0;
    end else if (inc_i && (q_o != {WIDTH{1'b1}})) begin
      q_o <= q_o + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing around ID: load-use bubble, taken-branch flush,
// data-memory freeze with timeout, and stall/flush statistics.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [4:0]       RS1addr_i,
  input  logic [4:0]       RS2addr_i,
  input  logic             RS1use_i,
  input  logic             RS2use_i,
  input  logic             IDEX_MemRead_i,
  input  logic [4:0]       IDEX_RDaddr_i,
  input  logic             Branch_i,
  input  logic             BranchTaken_i,
  input  logic             MemReq_i,
  input  logic             MemAck_i,
  output logic             PCWrite_o,
  output logic             IFIDWrite_o,
  output logic             IFIDFlush_o,
  output logic             IDEXNoOp_o,
  output logic             PipeWrite_o,
  output logic             MEMWBNoOp_o,
  output logic             Error_o,
  output logic [CNT_W-1:0] StallCnt_o,
  output logic [CNT_W-1:0] FlushCnt_o
);

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_e            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              error_q;

  logic active;
  logic memfrz;
  logic load_use;
  logic br_flush;
  logic stall_inc;

  // Hazard classification; priority is memory freeze, then load-use, then flush.
  always_comb begin
    active   = (state == ST_RUN) || (state == ST_MEM_WAIT);
    memfrz   = active && MemReq_i && !MemAck_i;
    load_use = active && !memfrz && IDEX_MemRead_i && (IDEX_RDaddr_i != REG_X0) &&
               (src_hits(RS1use_i, RS1addr_i, IDEX_RDaddr_i) ||
                src_hits(RS2use_i, RS2addr_i, IDEX_RDaddr_i));
    br_flush = active && !memfrz && !load_use && Branch_i && BranchTaken_i;
  end

  // Pipeline control outputs.
  always_comb begin
    PCWrite_o   = 1'b0;
    IFIDWrite_o = 1'b0;
    IFIDFlush_o = 1'b0;
    IDEXNoOp_o  = 1'b1;
    PipeWrite_o = 1'b0;
    MEMWBNoOp_o = 1'b1;
    if (active) begin
      if (memfrz) begin
        IDEXNoOp_o = 1'b0;
      end else if (load_use) begin
        PipeWrite_o = 1'b1;
        MEMWBNoOp_o = 1'b0;
      end else begin
        PCWrite_o   = 1'b1;
        IFIDWrite_o = 1'b1;
        IFIDFlush_o = br_flush;
        IDEXNoOp_o  = 1'b0;
        PipeWrite_o = 1'b1;
        MEMWBNoOp_o = 1'b0;
      end
    end
  end

  assign stall_inc = active && !PCWrite_o;
  assign Error_o   = error_q;

  // State, wait counter and sticky error.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      error_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (memfrz) begin
            state    <= ST_MEM_WAIT;
            wait_cnt <= '0;
          end
        end
        ST_MEM_WAIT: begin
          if (!memfrz) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
          end else if (wait_cnt == WAIT_LAST) begin
            state    <= ST_HALT;
            wait_cnt <= '0;
            error_q  <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        default: begin
          state <= ST_HALT;
        end
      endcase
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .clr_i (rst_i),
    .inc_i (stall_inc),
    .q_o   (StallCnt_o)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk_i (clk_i),
    .clr_i (rst_i),
    .inc_i (IFIDFlush_o),
    .q_o   (FlushCnt_o)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed and randomized checks of pipeline_hazard_ctrl against a cycle-level reference model.
module tb_pipeline_hazard_ctrl;

  localparam int CW   = 4;
  localparam int TMO  = 4;
  localparam int CMAX = 15;

  logic          clk = 1'b0;
  logic          rst_i = 1'b0;
  logic          start_i = 1'b0;
  logic [4:0]    RS1addr_i = '0;
  logic [4:0]    RS2addr_i = '0;
  logic          RS1use_i = 1'b0;
  logic          RS2use_i = 1'b0;
  logic          IDEX_MemRead_i = 1'b0;
  logic [4:0]    IDEX_RDaddr_i = '0;
  logic          Branch_i = 1'b0;
  logic          BranchTaken_i = 1'b0;
  logic          MemReq_i = 1'b0;
  logic          MemAck_i = 1'b0;
  logic          PCWrite_o, IFIDWrite_o, IFIDFlush_o, IDEXNoOp_o;
  logic          PipeWrite_o, MEMWBNoOp_o, Error_o;
  logic [CW-1:0] StallCnt_o, FlushCnt_o;

  pipeline_hazard_ctrl #(.CNT_W(CW), .MEM_TIMEOUT(TMO)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .start_i        (start_i),
    .RS1addr_i      (RS1addr_i),
    .RS2addr_i      (RS2addr_i),
    .RS1use_i       (RS1use_i),
    .RS2use_i       (RS2use_i),
    .IDEX_MemRead_i (IDEX_MemRead_i),
    .IDEX_RDaddr_i  (IDEX_RDaddr_i),
    .Branch_i       (Branch_i),
    .BranchTaken_i  (BranchTaken_i),
    .MemReq_i       (MemReq_i),
    .MemAck_i       (MemAck_i),
    .PCWrite_o      (PCWrite_o),
    .IFIDWrite_o    (IFIDWrite_o),
    .IFIDFlush_o    (IFIDFlush_o),
    .IDEXNoOp_o     (IDEXNoOp_o),
    .PipeWrite_o    (PipeWrite_o),
    .MEMWBNoOp_o    (MEMWBNoOp_o),
    .Error_o        (Error_o),
    .StallCnt_o     (StallCnt_o),
    .FlushCnt_o     (FlushCnt_o)
  );

  always #5 clk = ~clk;

  // Reference model: mode 0=idle 1=run 2=waiting on memory 3=halted.
  int m_mode = 0;
  int m_wait = 0;
  int m_err  = 0;
  int m_sc   = 0;
  int m_fc   = 0;
  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Check outputs mid-cycle, then advance the model across the rising edge.
  task automatic step();
    bit run, frz, hz, fl, adv;
    #2;
    run = (m_mode == 1) || (m_mode == 2);
    frz = run && MemReq_i && !MemAck_i;
    hz  = run && !frz && IDEX_MemRead_i && (IDEX_RDaddr_i != 0) &&
          ((RS1use_i && RS1addr_i == IDEX_RDaddr_i) || (RS2use_i && RS2addr_i == IDEX_RDaddr_i));
    fl  = run && !frz && !hz && Branch_i && BranchTaken_i;
    adv = run && !frz && !hz;
    chk("pcwrite",   int'(PCWrite_o),   int'(adv));
    chk("ifidwrite", int'(IFIDWrite_o), int'(adv));
    chk("ifidflush", int'(IFIDFlush_o), int'(fl));
    chk("idexnoop",  int'(IDEXNoOp_o),  int'(!run || hz));
    chk("pipewrite", int'(PipeWrite_o), int'(run && !frz));
    chk("memwbnoop", int'(MEMWBNoOp_o), int'(!run || frz));
    chk("error",     int'(Error_o),     m_err);
    chk("stallcnt",  int'(StallCnt_o),  m_sc);
    chk("flushcnt",  int'(FlushCnt_o),  m_fc);
    @(posedge clk);
    if (rst_i) begin
      m_mode = 0; m_wait = 0; m_err = 0; m_sc = 0; m_fc = 0;
    end else begin
      if (run && !adv && m_sc < CMAX) m_sc++;
      if (fl && m_fc < CMAX) m_fc++;
      case (m_mode)
        0: if (start_i) m_mode = 1;
        1: if (frz) begin m_mode = 2; m_wait = 0; end
        2: begin
          if (!frz) begin
            m_mode = 1; m_wait = 0;
          end else begin
            m_wait++;
            if (m_wait == TMO) begin m_mode = 3; m_wait = 0; m_err = 1; end
          end
        end
        default: ;
      endcase
    end
    #1;
  endtask

  task automatic quiet();
    start_i = 0; RS1use_i = 0; RS2use_i = 0; IDEX_MemRead_i = 0;
    Branch_i = 0; BranchTaken_i = 0; MemReq_i = 0; MemAck_i = 0;
    RS1addr_i = '0; RS2addr_i = '0; IDEX_RDaddr_i = '0;
  endtask

  initial begin
    // Reset, then idle with start low.
    quiet();
    rst_i = 1; step(); rst_i = 0;
    repeat (5) step();
    chk("idle_pcwrite", int'(PCWrite_o), 0);
    start_i = 1; step(); start_i = 0;
    step();
    chk("run_pcwrite", int'(PCWrite_o), 1);

    // Load-use on rs2 gives one bubble.
    IDEX_MemRead_i = 1; IDEX_RDaddr_i = 5'd5; RS2use_i = 1; RS2addr_i = 5'd5;
    step();
    quiet(); step();
    chk("t2_stallcnt", int'(StallCnt_o), 1);

    // x0 destination never stalls; branch blocked by load-use flushes next cycle.
    IDEX_MemRead_i = 1; IDEX_RDaddr_i = 5'd0; RS2use_i = 1; RS2addr_i = 5'd0;
    step();
    quiet();
    IDEX_MemRead_i = 1; IDEX_RDaddr_i = 5'd7; RS1use_i = 1; RS1addr_i = 5'd7;
    Branch_i = 1; BranchTaken_i = 1;
    step();
    IDEX_MemRead_i = 0;
    step();
    quiet();
    chk("t3_flushcnt", int'(FlushCnt_o), 1);
    chk("t3_stallcnt", int'(StallCnt_o), 2);

    // Zero-wait access, then a 3-cycle freeze released by ack.
    MemReq_i = 1; MemAck_i = 1; step();
    MemAck_i = 0; repeat (3) step();
    MemAck_i = 1; step();
    quiet(); step();
    chk("t4_stallcnt", int'(StallCnt_o), 5);

    // Timeout: freeze with no ack until HALT; start is ignored there.
    MemReq_i = 1; step();
    repeat (TMO) step();
    chk("t5_error", int'(Error_o), 1);
    quiet(); start_i = 1; repeat (2) step();
    chk("t5_halt_pcwrite", int'(PCWrite_o), 0);
    quiet(); rst_i = 1; step(); rst_i = 0;
    chk("t5_rst_error", int'(Error_o), 0);
    chk("t5_rst_stall", int'(StallCnt_o), 0);

    // Flush counter saturation.
    start_i = 1; step(); quiet();
    Branch_i = 1; BranchTaken_i = 1;
    repeat (20) step();
    quiet(); step();
    chk("t6_flush_sat", int'(FlushCnt_o), CMAX);

    // Randomized traffic with occasional resets and starts.
    rst_i = 1; step(); rst_i = 0;
    for (int i = 0; i < 600; i++) begin
      rst_i          = ($urandom_range(0, 59) == 0);
      start_i        = ($urandom_range(0, 3) == 0);
      RS1addr_i      = 5'($urandom_range(0, 3));
      RS2addr_i      = 5'($urandom_range(0, 3));
      RS1use_i       = 1'($urandom);
      RS2use_i       = 1'($urandom);
      IDEX_MemRead_i = 1'($urandom);
      IDEX_RDaddr_i  = 5'($urandom_range(0, 3));
      Branch_i       = 1'($urandom);
      BranchTaken_i  = 1'($urandom);
      MemReq_i       = ($urandom_range(0, 3) == 0);
      MemAck_i       = ($urandom_range(0, 2) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
